// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes, state encoding and priority helper for the round-robin arbiter
package arb_pkg;
  localparam int NREQ = 8;
  localparam int IDX_W = 3;
  localparam int MAX_HOLD_DEF = 255;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
  function automatic logic [IDX_W-1:0] first_set(input logic [NREQ-1:0] v);
    first_set = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (v[i]) first_set = IDX_W'(i);
  endfunction
endpackage

// File: rtl/dec_3_8.sv
// dec_3_8: 3-to-8 active-high one-hot decoder with enable
module dec_3_8 (
  input  logic [2:0] a,
  input  logic       en,
  output logic [7:0] y
);
  assign y = en ? (8'd1 << a) : 8'd0;
endmodule

// File: rtl/arb_rr_8.sv
// arb_rr_8: 8-way round-robin arbiter, non-preemptive, one idle cycle between grants.
// Define ARB_TIMEOUT_EN to add a watchdog that revokes grants held MAX_HOLD cycles.
module arb_rr_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("arb_rr_8: MAX_HOLD must be 1..255");
  end
  arb_state_t       state;
  logic [IDX_W-1:0] ptr, sel;
  logic [NREQ-1:0]  rot;
  logic             rel, expire;
  // rotate req so bit 0 is the requester at ptr, then find the first one upward
  always_comb begin
    for (int i = 0; i < NREQ; i++) rot[i] = req[IDX_W'(ptr + IDX_W'(i))];
    sel = ptr + first_set(rot);
  end
  assign rel = done | ~req[gnt_idx];
  assign gnt_valid = (state == GRANT);
  dec_3_8 u_dec (.a(gnt_idx), .en(gnt_valid), .y(gnt));
`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold;
  assign expire = gnt_valid & ~rel & ((hold + 8'd1) == 8'(MAX_HOLD));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold    <= 8'd0;
      timeout <= 1'b0;
    end else begin
      hold    <= gnt_valid ? hold + 8'd1 : 8'd0;
      timeout <= expire;
    end
  end
`else
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        gnt_idx <= sel;
        state   <= GRANT;
      end
    end else if (rel | expire) begin
      state <= IDLE;
      ptr   <= gnt_idx + IDX_W'(1);
    end
  end
endmodule

// File: tb/tb_arb_rr_8.sv
// tb_arb_rr_8: directed vector table plus hand sequences for rotation, watchdog and async reset
module tb_arb_rr_8;
  import arb_pkg::*;
  logic       clk = 1'b0, rst_n = 1'b0, done = 1'b0;
  logic [7:0] req = 8'h00, gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid, timeout;
  int ntests = 0, nfail = 0;
  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
  } vec_t;
  vec_t tbl[18];
  arb_rr_8 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic [7:0] r, input logic d);
    req = r;
    done = d;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_gnt(input string name, input logic [7:0] g, input logic [2:0] idx);
    chk({name, ".gnt"}, gnt, g);
    chk({name, ".valid"}, {7'd0, gnt_valid}, {7'd0, |g});
    if (|g) chk({name, ".idx"}, {5'd0, gnt_idx}, {5'd0, idx});
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    req = 8'h00;
    done = 1'b0;
    #1;
    chk("rst.gnt", gnt, 8'h00);
    chk("rst.valid", {7'd0, gnt_valid}, 8'h00);
    chk("rst.timeout", {7'd0, timeout}, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{8'h01, 1'b0, 8'h01, 3'd0};
    tbl[1]  = '{8'h01, 1'b1, 8'h00, 3'd0};
    tbl[2]  = '{8'h00, 1'b0, 8'h00, 3'd0};
    tbl[3]  = '{8'h00, 1'b1, 8'h00, 3'd0};
    tbl[4]  = '{8'h05, 1'b0, 8'h04, 3'd2};
    tbl[5]  = '{8'h05, 1'b0, 8'h04, 3'd2};
    tbl[6]  = '{8'h01, 1'b0, 8'h00, 3'd0};
    tbl[7]  = '{8'hFF, 1'b0, 8'h08, 3'd3};
    tbl[8]  = '{8'hF7, 1'b1, 8'h00, 3'd0};
    tbl[9]  = '{8'hFF, 1'b0, 8'h10, 3'd4};
    tbl[10] = '{8'hFF, 1'b1, 8'h00, 3'd0};
    tbl[11] = '{8'h20, 1'b0, 8'h20, 3'd5};
    tbl[12] = '{8'h20, 1'b1, 8'h00, 3'd0};
    tbl[13] = '{8'h05, 1'b0, 8'h01, 3'd0};
    tbl[14] = '{8'h05, 1'b1, 8'h00, 3'd0};
    tbl[15] = '{8'h05, 1'b0, 8'h04, 3'd2};
    tbl[16] = '{8'h05, 1'b1, 8'h00, 3'd0};
    tbl[17] = '{8'h00, 1'b0, 8'h00, 3'd0};
    #1;
    chk("init.gnt", gnt, 8'h00);
    chk("init.idx", {5'd0, gnt_idx}, 8'h00);
    chk("init.valid", {7'd0, gnt_valid}, 8'h00);
    chk("init.timeout", {7'd0, timeout}, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].req, tbl[i].done);
      expect_gnt($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx);
      chk($sformatf("vec%0d.timeout", i), {7'd0, timeout}, 8'h00);
    end
    do_reset();
    for (int g = 0; g < 9; g++) begin
      logic [2:0] e;
      logic [7:0] oh;
      e = 3'(g % 8);
      oh = 8'd1 << e;
      step(8'hFF, 1'b0);
      expect_gnt($sformatf("rot%0d.enter", g), oh, e);
      step(8'hFF, 1'b0);
      expect_gnt($sformatf("rot%0d.c1", g), oh, e);
      step(8'hFF, 1'b0);
      expect_gnt($sformatf("rot%0d.c2", g), oh, e);
      step(8'hFF, 1'b1);
      expect_gnt($sformatf("rot%0d.gap", g), 8'h00, 3'd0);
    end
    do_reset();
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      step(8'h10, 1'b0);
      expect_gnt($sformatf("wd.hold%0d", c), 8'h10, 3'd4);
      chk($sformatf("wd.hold%0d.to", c), {7'd0, timeout}, 8'h00);
    end
    step(8'h10, 1'b0);
    expect_gnt("wd.revoke", 8'h00, 3'd0);
    chk("wd.revoke.to", {7'd0, timeout}, 8'h01);
    step(8'h10, 1'b0);
    expect_gnt("wd.regrant", 8'h10, 3'd4);
    chk("wd.regrant.to", {7'd0, timeout}, 8'h00);
    for (int c = 0; c < 3; c++) begin
      step(8'h10, 1'b0);
      expect_gnt($sformatf("wd.rehold%0d", c), 8'h10, 3'd4);
    end
    step(8'h10, 1'b1);
    expect_gnt("wd.donelimit", 8'h00, 3'd0);
    chk("wd.donelimit.to", {7'd0, timeout}, 8'h00);
`else
    for (int c = 0; c < 300; c++) begin
      step(8'h10, 1'b0);
      expect_gnt($sformatf("hold%0d", c), 8'h10, 3'd4);
      chk($sformatf("hold%0d.to", c), {7'd0, timeout}, 8'h00);
    end
    step(8'h10, 1'b1);
    expect_gnt("hold.release", 8'h00, 3'd0);
`endif
    step(8'h08, 1'b0);
    expect_gnt("ar.pre", 8'h08, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.gnt", gnt, 8'h00);
    chk("ar.valid", {7'd0, gnt_valid}, 8'h00);
    chk("ar.timeout", {7'd0, timeout}, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(8'h81, 1'b0);
    expect_gnt("ar.from0", 8'h01, 3'd0);
    step(8'h81, 1'b1);
    expect_gnt("ar.rel0", 8'h00, 3'd0);
    step(8'h80, 1'b0);
    expect_gnt("ar.g7", 8'h80, 3'd7);
    step(8'h80, 1'b1);
    expect_gnt("ar.rel7", 8'h00, 3'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/arb_rr_8.md
ARB_RR_8 -- requirements
Module: arb_rr_8

Interface
REQ-001 Parameter: MAX_HOLD, default 255, maximum grant length in cycles when timeout is compiled in (range 1..255).
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  request per requester; bit i high = requester i wants the shared resource.
REQ-005 done  input  1  single-cycle pulse from current owner: transfer finished, release grant.
REQ-006 gnt  output  8  one-hot grant; all-zero when no grant held.
REQ-007 gnt_idx  output  3  binary index of current owner; valid only while gnt_valid high.
REQ-008 gnt_valid  output  1  high while any grant is held (equals OR of gnt).
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog; constant 0 when watchdog is compiled out.

Function
REQ-010 FSM states: IDLE, GRANT; only these two states are reachable.
REQ-011 IDLE: when req != 0, select the first asserted bit searching upward from ptr with wrap 7->0, register it in gnt_idx, enter GRANT.
REQ-012 Latency: gnt asserts on the first rising edge after req is sampled non-zero in IDLE (1 cycle).
REQ-013 IDLE with req == 0: remain in IDLE, gnt = 0, gnt_valid = 0.
REQ-014 GRANT: gnt = one-hot decode of gnt_idx; gnt_idx and gnt stable for the whole GRANT interval.
REQ-015 GRANT release on done = 1 OR req[gnt_idx] = 0 (owner withdrawal); next state IDLE, ptr <= gnt_idx + 1 modulo 8.
REQ-016 done and owner withdrawal in the same cycle count as one release.
REQ-017 done while in IDLE is ignored.
REQ-018 Requests from non-owners during GRANT are ignored until return to IDLE; no preemption.
REQ-019 Exactly one IDLE cycle between consecutive grants (grant gap = 1 cycle), including back-to-back to the same requester.
REQ-020 Fairness: with all 8 requesting continuously, grants rotate 0,1,...,7,0 with no requester granted twice before every other requester has been granted once.

Reset
REQ-021 rst_n low: state = IDLE, ptr = 0, gnt_idx = 0, gnt = 0, gnt_valid = 0, timeout = 0, hold counter = 0, all immediately and without clk.
REQ-022 Reset asserted mid-GRANT drops grant asynchronously; first grant after reset searches from requester 0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: 8-bit hold counter clears on GRANT entry, increments each GRANT cycle; when it reaches MAX_HOLD with no release, grant revoked (as REQ-015, ptr advances), timeout pulses 1 cycle on the same edge GRANT exits.
REQ-024 Normal release in the same cycle as the limit takes precedence: no timeout pulse.
REQ-025 Macro undefined: no counter logic, grants held indefinitely, timeout tied 0.

Structure
REQ-026 Package arb_pkg holds: NREQ = 8, IDX_W = 3, MAX_HOLD_DEF = 255, typedef enum arb_state_t {IDLE, GRANT}.
REQ-027 gnt generated by instantiating the team's existing 3-to-8 active-high decoder dec_3_8 on gnt_idx, gated by gnt_valid; rotating priority search kept in arb_rr_8.

Verification
REQ-028 Reset then req = 8'h01 -> gnt = 8'h01, gnt_idx = 0 one cycle later; done pulse -> gnt = 0 next cycle.
REQ-029 req = 8'hFF held, done every 3rd GRANT cycle -> gnt sequence 01,02,04,...,80,01 with one zero cycle between each.
REQ-030 ptr = 6, req = 8'h05 -> grant to requester 0 (wrap), then requester 2.
REQ-031 Owner 3 drops req[3] with done high same cycle -> single release, next grant to next requester above 3, no double advance.
REQ-032 ARB_TIMEOUT_EN, MAX_HOLD = 4, req = 8'h10 held, no done -> grant revoked after 4 GRANT cycles, timeout = 1 for one cycle, regrant to 4 after 1 IDLE cycle.
REQ-033 rst_n pulled low mid-GRANT between clock edges -> gnt = 0 immediately; after release with req = 8'h80, grant to 7.
